// File: rtl/step_session_ctrl.sv
// ---------------------------------------------------------------------------
// step_session_ctrl
//
// Session controller for the pedometer datapath. Runs one measurement session
// while start is high. It synchronizes the raw step input, derives a 1-second
// tick from the system clock and closes a per-second step window on each tick.
// During the first WINDOW_SEC seconds it scores "fast" seconds (at least
// FAST_THRESH steps). It also keeps running totals for the display.
//
// Optional feature: define STEP_DEBOUNCE_EN to insert a debouncer between the
// synchronizer and the edge detector. The filtered level follows the
// synchronized input only after DEBOUNCE_CYC stable cycles.
//
// Ports
//   clk          in   system clock, rising edge
//   resetN       in   asynchronous active-low reset
//   start        in   1 = run session, 0 = stop (synchronous level)
//   stepIn       in   raw step pulse, asynchronous to clk
//   secTick      out  one-cycle pulse at each second boundary while running
//   windowActive out  high while inside the first WINDOW_SEC seconds
//   windowDone   out  high after the window closes, until the next session
//   stepsLastSec out  steps in the most recently closed second (sat 511)
//   fastSecs     out  fast seconds in the window (sat FAST_CAP)
//   totalSteps   out  steps this session (sat 65535)
//   elapsedSec   out  seconds this session (sat 16383)
// ---------------------------------------------------------------------------
module step_session_ctrl #(
  parameter int CLK_HZ       = 100000000,
  parameter int WINDOW_SEC   = 10,
  parameter int FAST_THRESH  = 33,
  parameter int FAST_CAP     = 9,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  input  logic        stepIn,
  output logic        secTick,
  output logic        windowActive,
  output logic        windowDone,
  output logic [8:0]  stepsLastSec,
  output logic [3:0]  fastSecs,
  output logic [15:0] totalSteps,
  output logic [13:0] elapsedSec
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_TC = PW'(CLK_HZ - 1);
  localparam logic [13:0]   WIN_SEC  = 14'(WINDOW_SEC);
  localparam logic [8:0]    FAST_TH  = 9'(FAST_THRESH);
  localparam logic [3:0]    FAST_MAX = 4'(FAST_CAP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    TRACK  = 2'd2
  } state_t;

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  function automatic logic [13:0] sat_inc14(input logic [13:0] v);
    return (v == 14'h3FFF) ? v : v + 14'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t        state_q;
  logic [PW-1:0] presc_q;
  logic [8:0]    perSec_q;
  logic [8:0]    stepsLastSec_q;
  logic [3:0]    fastSecs_q;
  logic [15:0]   totalSteps_q;
  logic [13:0]   elapsedSec_q;
  logic          windowActive_q;
  logic          windowDone_q;

  logic          sync1_q, sync2_q;
  logic          prevLvl_q;
  logic          stepEdge_q;
  logic          stepLvl;

  logic [8:0]    perSec_d;
  logic [15:0]   totalSteps_d;
  logic [13:0]   elapsedSec_d;
  logic          tick;

  // Synchronizer stage: two flops bring stepIn into the clk domain
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= stepIn;
      sync2_q <= sync1_q;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
  localparam logic [DW-1:0] DB_TC = DW'(DEBOUNCE_CYC - 1);

  logic          filt_q;
  logic [DW-1:0] dbCnt_q;

  // Debounce stage: the count runs only while the input differs from the
  // filtered level, so any bounce back restarts the stability interval.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      filt_q  <= 1'b0;
      dbCnt_q <= '0;
    end else if (sync2_q == filt_q) begin
      dbCnt_q <= '0;
    end else if (dbCnt_q == DB_TC) begin
      filt_q  <= sync2_q;
      dbCnt_q <= '0;
    end else begin
      dbCnt_q <= dbCnt_q + 1'b1;
    end
  end

  assign stepLvl = filt_q;
`else
  assign stepLvl = sync2_q;
`endif

  // Edge-detect stage: registered so a step reaches the counters one edge
  // after it is detected
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prevLvl_q  <= 1'b0;
      stepEdge_q <= 1'b0;
    end else begin
      prevLvl_q  <= stepLvl;
      stepEdge_q <= stepLvl & ~prevLvl_q;
    end
  end

  assign tick = (state_q != IDLE) && (presc_q == PRESC_TC);

  // A step landing in the tick cycle belongs to the closing second, so the
  // closing count is taken after this cycle's increment.
  always_comb begin
    perSec_d     = perSec_q;
    totalSteps_d = totalSteps_q;
    if (stepEdge_q) begin
      perSec_d     = sat_inc9(perSec_q);
      totalSteps_d = sat_inc16(totalSteps_q);
    end
    elapsedSec_d = sat_inc14(elapsedSec_q);
  end

  // Session FSM and counters
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      presc_q        <= '0;
      perSec_q       <= '0;
      stepsLastSec_q <= '0;
      fastSecs_q     <= '0;
      totalSteps_q   <= '0;
      elapsedSec_q   <= '0;
      windowActive_q <= 1'b0;
      windowDone_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q        <= WINDOW;
            presc_q        <= '0;
            perSec_q       <= '0;
            stepsLastSec_q <= '0;
            fastSecs_q     <= '0;
            totalSteps_q   <= '0;
            elapsedSec_q   <= '0;
            windowActive_q <= 1'b1;
            windowDone_q   <= 1'b0;
          end
        end
        default: begin
          if (!start) begin
            // Stop wins over a coincident tick; counts hold for the display
            state_q        <= IDLE;
            presc_q        <= '0;
            perSec_q       <= '0;
            windowActive_q <= 1'b0;
          end else begin
            totalSteps_q <= totalSteps_d;
            if (tick) begin
              presc_q        <= '0;
              perSec_q       <= '0;
              stepsLastSec_q <= perSec_d;
              elapsedSec_q   <= elapsedSec_d;
              if (state_q == WINDOW) begin
                if ((perSec_d >= FAST_TH) && (fastSecs_q < FAST_MAX))
                  fastSecs_q <= fastSecs_q + 4'd1;
                if (elapsedSec_d == WIN_SEC) begin
                  state_q        <= TRACK;
                  windowActive_q <= 1'b0;
                  windowDone_q   <= 1'b1;
                end
              end
            end else begin
              presc_q  <= presc_q + 1'b1;
              perSec_q <= perSec_d;
            end
          end
        end
      endcase
    end
  end

  assign secTick      = tick;
  assign windowActive = windowActive_q;
  assign windowDone   = windowDone_q;
  assign stepsLastSec = stepsLastSec_q;
  assign fastSecs     = fastSecs_q;
  assign totalSteps   = totalSteps_q;
  assign elapsedSec   = elapsedSec_q;

endmodule
